// File: rtl/mmio_responder.sv
// mmio_responder: data-side memory-mapped I/O responder on the core's M-stage bus.
// It decodes the I/O window selected by mem_adr[31:28] == IO_BASE_NIB, returns
// registered read data one cycle later (W stage), and contains a byte-wide TX FIFO
// toward the UART, a one-byte RX holding register and performance counters.
// Optional feature: define MMIO_COUNTERS_EN to build the CYCLE/INSTRET counters
// and the CNTRST clear register; without it those offsets read 0 and writes are ignored.
module mmio_responder #(
    parameter int         XLEN        = 32,
    parameter int         TX_DEPTH    = 4,
    parameter logic [3:0] IO_BASE_NIB = 4'h8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      wea,
    input  logic            rd_en,
    input  logic            instr_stop,
    output logic            io_sel,
    output logic [XLEN-1:0] io_rdata,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data_in,
    input  logic            rx_valid,
    output logic            rx_ready
);

    // Pointer index width; pointers carry one extra wrap bit to tell full from empty.
    localparam int PW = (TX_DEPTH < 2) ? 1 : $clog2(TX_DEPTH);

    // Register offsets within the I/O window.
    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RXDATA  = 8'h04;
    localparam logic [7:0] OFF_TXDATA  = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTRET = 8'h14;
    localparam logic [7:0] OFF_CNTRST  = 8'h18;

    localparam logic [PW:0]     PTR_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]     PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    // Bus decode
    logic       hit_s;
    logic [7:0] offset_s;
    logic       isStore_s;
    logic       rdHit_s;

    // TX FIFO
    logic [7:0]  txMem_r [TX_DEPTH];
    logic [PW:0] wrPtr_r;
    logic [PW:0] rdPtr_r;
    logic        txFull_s;
    logic        txEmpty_s;
    logic        txPop_s;
    logic        txPushReq_s;
    logic        txPushOk_s;
    logic        ovfSet_s;
    logic        ovfClr_s;
    logic        ovf_r;

    // RX holding register
    logic       rxFull_r;
    logic [7:0] rxBuf_r;
    logic       rxPop_s;
    logic       rxAccept_s;

    // Read path
    logic [XLEN-1:0] rdData_s;
    logic [XLEN-1:0] ioRdata_r;
    logic            ioSel_r;

`ifdef MMIO_COUNTERS_EN
    // Performance counters
    logic [XLEN-1:0] cycle_r;
    logic [XLEN-1:0] instret_r;
    logic            cntClr_s;
    localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    // Bits of the bus that this block never looks at.
    logic unusedBits_s;
    assign unusedBits_s = ^{mem_adr[27:8], mem_wdata[XLEN-1:8]};
`else
    // Bits of the bus that this block never looks at; instr_stop only feeds the counters.
    logic unusedBits_s;
    assign unusedBits_s = ^{mem_adr[27:8], mem_wdata[XLEN-1:8], instr_stop};
`endif

    // Address window decode and access qualification.
    always_comb begin
        hit_s     = (mem_adr[31:28] == IO_BASE_NIB);
        offset_s  = mem_adr[7:0];
        isStore_s = (wea != 4'b0000);
        rdHit_s   = hit_s & rd_en;
    end

    // FIFO occupancy and the push/pop/overflow decisions for this cycle.
    always_comb begin
        txEmpty_s   = (wrPtr_r == rdPtr_r);
        txFull_s    = (wrPtr_r[PW] != rdPtr_r[PW]) &&
                      (wrPtr_r[PW-1:0] == rdPtr_r[PW-1:0]);
        txPop_s     = !txEmpty_s & tx_ready;
        txPushReq_s = hit_s & isStore_s & (offset_s == OFF_TXDATA);
        // A simultaneous pop frees the slot the push needs, so full only blocks
        // the push when nothing leaves this cycle.
        txPushOk_s  = txPushReq_s & (!txFull_s | txPop_s);
        ovfSet_s    = txPushReq_s & txFull_s & !txPop_s;
        ovfClr_s    = rdHit_s & (offset_s == OFF_STATUS);
    end

    // RX pop on an RXDATA load with a byte held; accept a new byte only when empty.
    always_comb begin
        rxPop_s    = rdHit_s & (offset_s == OFF_RXDATA) & rxFull_r;
        rxAccept_s = rx_valid & !rxFull_r;
    end

`ifdef MMIO_COUNTERS_EN
    // Counter clear strobe from a store to CNTRST.
    always_comb begin
        cntClr_s = hit_s & isStore_s & (offset_s == OFF_CNTRST);
    end
`endif

    // Read mux: register contents before this edge's updates.
    always_comb begin
        rdData_s = DATA_ZERO;
        if (hit_s) begin
            case (offset_s)
                OFF_STATUS: begin
                    rdData_s[0] = !txFull_s;
                    rdData_s[1] = rxFull_r;
                    rdData_s[2] = ovf_r;
                end
                OFF_RXDATA: begin
                    rdData_s[7:0] = rxBuf_r;
                end
`ifdef MMIO_COUNTERS_EN
                OFF_CYCLE: begin
                    rdData_s = cycle_r;
                end
                OFF_INSTRET: begin
                    rdData_s = instret_r;
                end
`endif
                default: begin
                    rdData_s = DATA_ZERO;
                end
            endcase
        end else begin
            rdData_s = DATA_ZERO;
        end
    end

    // W-stage read data and select, one cycle behind the M-stage access.
    always_ff @(posedge clk) begin
        if (rst) begin
            ioRdata_r <= DATA_ZERO;
            ioSel_r   <= 1'b0;
        end else begin
            ioRdata_r <= rdData_s;
            ioSel_r   <= rdHit_s;
        end
    end

    // TX FIFO storage and pointers; reset discards anything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r <= PTR_ZERO;
            rdPtr_r <= PTR_ZERO;
            for (int i = 0; i < TX_DEPTH; i++) begin
                txMem_r[i] <= 8'h00;
            end
        end else begin
            if (txPushOk_s) begin
                txMem_r[wrPtr_r[PW-1:0]] <= mem_wdata[7:0];
                wrPtr_r                  <= wrPtr_r + PTR_ONE;
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (txPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end else begin
                rdPtr_r <= rdPtr_r;
            end
        end
    end

    // Sticky overflow flag, cleared by reading STATUS.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (ovfSet_s) begin
            ovf_r <= 1'b1;
        end else if (ovfClr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // RX holding register: accept from the receiver when empty, empty on RXDATA read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxFull_r <= 1'b0;
            rxBuf_r  <= 8'h00;
        end else if (rxPop_s) begin
            rxFull_r <= 1'b0;
            rxBuf_r  <= rxBuf_r;
        end else if (rxAccept_s) begin
            rxFull_r <= 1'b1;
            rxBuf_r  <= rx_data_in;
        end else begin
            rxFull_r <= rxFull_r;
            rxBuf_r  <= rxBuf_r;
        end
    end

`ifdef MMIO_COUNTERS_EN
    // Cycle and retired-instruction counters; CNTRST wins over the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_r   <= DATA_ZERO;
            instret_r <= DATA_ZERO;
        end else if (cntClr_s) begin
            cycle_r   <= DATA_ZERO;
            instret_r <= DATA_ZERO;
        end else begin
            cycle_r <= cycle_r + CNT_ONE;
            if (!instr_stop) begin
                instret_r <= instret_r + CNT_ONE;
            end else begin
                instret_r <= instret_r;
            end
        end
    end
`endif

    assign io_rdata = ioRdata_r;
    assign io_sel   = ioSel_r;
    assign tx_valid = !txEmpty_s;
    assign tx_data  = txMem_r[rdPtr_r[PW-1:0]];
    assign rx_ready = !rxFull_r;

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Data-side memory-mapped I/O responder. It sits on the core's M-stage data bus (address, write data, byte enables) opposite the core, which is the initiator.
- It decodes the I/O window and returns registered read data in the W stage, matching the core's `din` timing.
- Contents: a UART-facing TX FIFO, a one-byte RX holding register, and cycle/instruction performance counters.
- The top level muxes `io_rdata` onto the core's `din` using `io_sel`.

Parameters:
- XLEN, 32, data/address width.
- TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- IO_BASE_NIB, 4'h8, value of `mem_adr[31:28]` that selects this block.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mem_adr  input  XLEN  M-stage byte address
- mem_wdata  input  XLEN  M-stage store data
- wea  input  4  byte write enables; any nonzero bit = store
- rd_en  input  1  M-stage load valid
- instr_stop  input  1  core not retiring this cycle (stall/redirect)
- io_sel  output  1  registered: the previous-cycle access hit the I/O window
- io_rdata  output  XLEN  registered read data, valid in the W stage
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  TX FIFO not empty
- tx_ready  input  1  transmitter accepts `tx_data`
- rx_data_in  input  8  byte from UART receiver
- rx_valid  input  1  receiver offers a byte
- rx_ready  output  1  RX holding register empty

Behaviour:
- Hit: `mem_adr[31:28]==IO_BASE_NIB`. Register select is `mem_adr[7:0]`. Non-hit accesses produce no side effects.
- Register map (offsets):
  - 0x00 STATUS (R): bit0 = TX not full, bit1 = RX full, bit2 = TX overflow (sticky), other bits 0.
  - 0x04 RXDATA (R): `{24'b0, rx_buf}`.
  - 0x08 TXDATA (W): push `mem_wdata[7:0]`.
  - 0x10 CYCLE (R).
  - 0x14 INSTRET (R).
  - 0x18 CNTRST (W): clears both counters.
  - Unmapped offsets: read 0, writes ignored.
- Read latency is 1 cycle.
  - On every edge, `io_rdata <= decode(mem_adr)` and `io_sel <= hit & rd_en`.
  - The read value is the register state before that edge's updates.
- Read side effects require `hit & rd_en`:
  - RXDATA read clears rx_full.
  - STATUS read clears the overflow bit.
  - Reading RXDATA while empty returns the stale byte, with no effect.
- TX FIFO:
  - Pointers are log2(TX_DEPTH)+1 bits wide and wrap naturally.
  - `tx_valid` = count != 0; `tx_data` = head entry (combinational from storage).
  - Pop when `tx_valid & tx_ready`. Push on `hit & wea!=0 & offset 0x08`.
  - Push while full and no pop: data dropped, overflow set.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push while empty: `tx_valid` rises the next cycle.
- RX:
  - `rx_ready = !rx_full`.
  - On `rx_valid & rx_ready`: latch `rx_data_in` into rx_buf and set rx_full.
  - An accept and an RXDATA pop cannot coincide (`rx_ready` is 0 when full).
- Counters (XLEN bits, wrap 2^XLEN-1 -> 0):
  - CYCLE increments every cycle.
  - INSTRET increments when `!instr_stop`.
  - A CNTRST write forces both to 0 at that edge; the increment is suppressed that cycle.
- Reset (synchronous, active-high, takes priority over everything) sets: `io_rdata`=0, `io_sel`=0, FIFO empty (`tx_valid`=0), overflow=0, rx_full=0 (`rx_ready`=1), rx_buf=0, both counters=0.
- Reset asserted mid-transfer discards FIFO contents and any held RX byte.

Optional Feature:
- Macro: MMIO_COUNTERS_EN.
- Defined: CYCLE, INSTRET and CNTRST behave as above.
- Undefined:
  - Counter registers are not synthesized.
  - Offsets 0x10/0x14 read 0 and writes to 0x18 are ignored.
  - `instr_stop` is unused.

Test Plan:
- Reset, then idle 10 cycles -> `tx_valid`=0, `rx_ready`=1, a STATUS read gives `io_rdata`=0x1 with `io_sel`=1 one cycle later; CYCLE read returns 10 ± read latency, exact value checked against a bench model.
- Store 0x41,0x42,0x43,0x44,0x45 to 0x80000008 with `tx_ready`=0 -> FIFO full after 4; the 5th is dropped; STATUS reads 0x4; a second STATUS read gives 0x0; release `tx_ready` -> `tx_data` sequence 0x41..0x44, then `tx_valid`=0.
- FIFO full, `tx_ready`=1 and a store of 0x55 in the same cycle -> no overflow, 0x55 emitted last.
- Drive `rx_valid` with 0x5A -> `rx_ready`=0 the next cycle; STATUS bit1=1; a load from 0x80000004 returns 0x0000005A and `rx_ready` returns to 1; a second byte 0x33 offered while full is held off until after the pop.
- Hold `instr_stop`=1 on 3 of 8 cycles -> INSTRET advances by 5 and CYCLE by 8; store to 0x80000018 -> both read 0 the next cycle. With MMIO_COUNTERS_EN undefined, both read 0 throughout.
- Assert `rst` with 2 bytes queued and rx_full=1 -> next cycle `tx_valid`=0, `rx_ready`=1, `io_rdata`=0; a load to 0x40000000 gives `io_sel`=0 and no side effects.
